// File: rtl/pdm_mic_capture.sv
// pdm_mic_capture: PDM microphone front end for the audio record path.
// Generates the microphone clock, samples the 1-bit PDM stream on each M_CLK
// rising edge, boxcar-decimates DECIM bits into one unsigned SAMPLE_W-bit PCM
// sample and writes the samples sequentially through an addra/dina/wea
// block-RAM port, the same format the PWM playback path reads.
// Optional feature: define MIC_CLIP_DETECT_EN to add a sticky 'clip' output
// that flags any closed window that was all ones or all zeros.
module pdm_mic_capture #(
  parameter int CLK_DIV  = 50,
  parameter int DECIM    = 256,
  parameter int SAMPLE_W = 12,
  parameter int ADDR_W   = 20,
  parameter int DEPTH    = 65536
) (
  input  logic                CLK100MHZ,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                M_DATA,
  output logic                M_CLK,
  output logic                M_LR_SEL,
  output logic [ADDR_W-1:0]   addra,
  output logic [SAMPLE_W-1:0] dina,
  output logic                wea,
  output logic                busy,
  output logic                done
`ifdef MIC_CLIP_DETECT_EN
  ,
  output logic                clip
`endif
);

  localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int LOG2_DECIM = $clog2(DECIM);
  localparam int ONES_W     = $clog2(DECIM + 1);
  localparam int SHIFT      = SAMPLE_W - LOG2_DECIM;

  localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [LOG2_DECIM-1:0] BIT_LAST  = LOG2_DECIM'(DECIM - 1);
  localparam logic [ONES_W-1:0]     CNT_MAX   = ONES_W'(DECIM - 1);
  localparam logic [ONES_W-1:0]     ONES_FULL = ONES_W'(DECIM);
  localparam logic [ADDR_W-1:0]     LAST_ADDR = ADDR_W'(DEPTH - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [DIV_W-1:0]      div_cnt;
  logic [1:0]            state;
  logic [ONES_W-1:0]     ones;
  logic [LOG2_DECIM-1:0] bit_cnt;
  logic                  stop_pend;

  logic                  rise;
  logic                  window_close;
  logic [ONES_W-1:0]     ones_total;
  logic [ONES_W-1:0]     cnt_sat;
  logic [SAMPLE_W-1:0]   sample_val;

  // The microphone only needs left-channel data, valid on the rising edge.
  assign M_LR_SEL = 1'b0;
  assign busy     = (state == S_CAPTURE);

  // The cycle in which M_CLK goes 0->1 is the cycle M_DATA gets sampled.
  assign rise         = (div_cnt == DIV_LAST) && !M_CLK;
  assign ones_total   = ones + ONES_W'(M_DATA);
  assign window_close = (state == S_CAPTURE) && rise && (bit_cnt == BIT_LAST);

  // Saturate a full window to DECIM-1 so it fits log2(DECIM) bits, then
  // left-justify into the PCM word.
  always_comb begin
    cnt_sat    = (ones_total > CNT_MAX) ? CNT_MAX : ones_total;
    sample_val = SAMPLE_W'(cnt_sat) << SHIFT;
  end

  // Free-running microphone clock divider; never reset by the FSM so the
  // microphone stays clocked between captures.
  // NOTE: every flop lists 'posedge rst' in its sensitivity so it clears the
  // moment rst rises, without waiting for a clock edge.
  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      M_CLK   <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      M_CLK   <= ~M_CLK;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Capture FSM: bit accumulation, window close, write strobe and addressing.
  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      addra     <= '0;
      dina      <= '0;
      wea       <= 1'b0;
      done      <= 1'b0;
      ones      <= '0;
      bit_cnt   <= '0;
      stop_pend <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so the default below and
      // any later override in the case resolve to "last assignment wins"
      // without read-after-write ordering hazards between flops.
      wea <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_CAPTURE;
            addra     <= '0;
            ones      <= '0;
            bit_cnt   <= '0;
            done      <= 1'b0;
            stop_pend <= 1'b0;
          end
        end
        S_CAPTURE: begin
          if (wea) begin
            // Write cycle: finish on the last address or a stop seen during
            // or just before the write, otherwise advance the address.
            if (stop || stop_pend || (addra == LAST_ADDR)) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              addra <= addra + ADDR_W'(1);
            end
          end else if (window_close) begin
            wea     <= 1'b1;
            dina    <= sample_val;
            ones    <= '0;
            bit_cnt <= '0;
            if (stop) begin
              stop_pend <= 1'b1;
            end
          end else if (stop) begin
            // Abort: the partial window is simply dropped.
            state <= S_DONE;
            done  <= 1'b1;
          end else if (rise) begin
            ones    <= ones_total;
            bit_cnt <= bit_cnt + LOG2_DECIM'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef MIC_CLIP_DETECT_EN
  // Sticky clip flag: a closed window pinned at either rail.
  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      clip <= 1'b0;
    end else if ((state == S_IDLE) && start) begin
      clip <= 1'b0;
    end else if (window_close && ((ones_total == ONES_FULL) || (ones_total == '0))) begin
      clip <= 1'b1;
    end
  end
`endif

endmodule
